attack_schedule_responder: RTL

ATTACK_SCHEDULE_RESPONDER -- requirements
Module: attack_schedule_responder

---
 rtl/attack_schedule_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/attack_schedule_responder.sv
`default_nettype none
// ============================================================================
// Module   : attack_schedule_responder
// Purpose  : Answers a runtime attack-time request. It fetches the attack
//            word from a synchronous ROM, computes the saturated absolute
//            spawn time and pulses update_attack_time. It then waits for the
//            runtime to acknowledge the response on sync_attack_time.
// Revision : 1.0 - initial release
// ============================================================================
module attack_schedule_responder #(
  parameter int MAXIMUM_TIMES         = 30,
  parameter int MAXIMUM_ATTACK_OBJECT = 20,
  parameter int ROM_ADDR_WIDTH        = 10,
  parameter int ROM_DEPTH             = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MAXIMUM_TIMES-1:0]         current_time,
  input  logic [MAXIMUM_ATTACK_OBJECT-1:0] attack_i,
  input  logic                             sync_attack_time,
  output logic [ROM_ADDR_WIDTH-1:0]        rom_addr,
  input  logic [31:0]                      rom_data,
  output logic [MAXIMUM_TIMES-1:0]         next_attack_time,
  output logic                             update_attack_time,
  output logic [3:0]                       attack_type,
  output logic [9:0]                       attack_pos_x,
  output logic [9:0]                       attack_pos_y,
  output logic                             busy
);

  // State encoding
  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_FETCH    = 3'd1;
  localparam logic [2:0] c_LATCH    = 3'd2;
  localparam logic [2:0] c_RESPOND  = 3'd3;
  localparam logic [2:0] c_WAIT_ACK = 3'd4;

  // The index is compared one bit wider so that ROM_DEPTH == 2^width still fits.
  localparam logic [MAXIMUM_ATTACK_OBJECT:0] c_ROM_DEPTH =
    (MAXIMUM_ATTACK_OBJECT+1)'(ROM_DEPTH);
  localparam logic [MAXIMUM_TIMES-1:0] c_TIME_MAX = '1;

  logic [2:0]                       r_state;
  logic [2:0]                       w_state_next;
  logic [MAXIMUM_ATTACK_OBJECT-1:0] r_attack_idx;
  logic [MAXIMUM_ATTACK_OBJECT-1:0] w_attack_idx;
  logic [ROM_ADDR_WIDTH-1:0]        r_rom_addr;
  logic [ROM_ADDR_WIDTH-1:0]        w_rom_addr;
  logic [MAXIMUM_TIMES-1:0]         r_next_time;
  logic [MAXIMUM_TIMES-1:0]         w_next_time;
  logic                             r_update;
  logic                             w_update;
  logic [3:0]                       r_type;
  logic [3:0]                       w_type;
  logic [9:0]                       r_pos_x;
  logic [9:0]                       r_pos_y;
  logic [9:0]                       w_pos_x;
  logic [9:0]                       w_pos_y;
  logic                             r_busy;
  logic                             w_busy;

  // The sum carries one extra bit, so an overflow shows up as the carry-out.
  logic [MAXIMUM_TIMES:0]           w_sum;
  logic                             w_out_of_range;

  assign w_sum = {1'b0, current_time}
               + {{(MAXIMUM_TIMES-7){1'b0}}, rom_data[31:24]};
  assign w_out_of_range = ({1'b0, r_attack_idx} >= c_ROM_DEPTH);

  // Register state and all outputs; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_attack_idx <= '0;
      r_rom_addr   <= '0;
      r_next_time  <= '0;
      r_update     <= 1'b0;
      r_type       <= '0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_attack_idx <= w_attack_idx;
      r_rom_addr   <= w_rom_addr;
      r_next_time  <= w_next_time;
      r_update     <= w_update;
      r_type       <= w_type;
      r_pos_x      <= w_pos_x;
      r_pos_y      <= w_pos_y;
      r_busy       <= w_busy;
    end
  end

  // Next-state logic; sync is only looked at in IDLE and WAIT_ACK
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:     if (!sync_attack_time) w_state_next = c_FETCH;
      c_FETCH:    w_state_next = c_LATCH;
      c_LATCH:    w_state_next = c_RESPOND;
      c_RESPOND:  w_state_next = c_WAIT_ACK;
      c_WAIT_ACK: if (sync_attack_time) w_state_next = c_IDLE;
      default:    w_state_next = c_IDLE;
    endcase
  end

  // Next values of the registered outputs, based on the current state
  always_comb begin
    w_attack_idx = r_attack_idx;
    w_rom_addr   = r_rom_addr;
    w_next_time  = r_next_time;
    w_type       = r_type;
    w_pos_x      = r_pos_x;
    w_pos_y      = r_pos_y;
    w_update     = 1'b0;
    w_busy       = (w_state_next != c_IDLE);
    case (r_state)
      c_IDLE: begin
        if (!sync_attack_time) begin
          w_attack_idx = attack_i;
          w_rom_addr   = attack_i[ROM_ADDR_WIDTH-1:0];
        end
      end
      c_LATCH: begin
        // The ROM word addressed from IDLE is valid in this cycle
        if (w_out_of_range) begin
          w_next_time = c_TIME_MAX;
          w_type      = '0;
          w_pos_x     = '0;
          w_pos_y     = '0;
        end else begin
          w_next_time = w_sum[MAXIMUM_TIMES] ? c_TIME_MAX
                                             : w_sum[MAXIMUM_TIMES-1:0];
          w_type      = rom_data[3:0];
          w_pos_x     = rom_data[23:14];
          w_pos_y     = rom_data[13:4];
        end
        // The pulse is registered here so that it appears during RESPOND
        w_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_addr           = r_rom_addr;
  assign next_attack_time   = r_next_time;
  assign update_attack_time = r_update;
  assign attack_type        = r_type;
  assign attack_pos_x       = r_pos_x;
  assign attack_pos_y       = r_pos_y;
  assign busy               = r_busy;

endmodule
`default_nettype wire
